// File: rtl/tone_pkg.sv
// Shared constants for the keypad tone generator: note table, FSM states, system clock rate.
package tone_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TONE  = 2'd1,
    S_HOLD  = 2'd2,
    S_CLICK = 2'd3
  } state_t;

  // Half-period in clk cycles at 50 MHz, indexed by key number.
  localparam logic [16:0] NOTE_HALF [16] = '{
    17'd21294, 17'd23900, 17'd25303, 17'd28409,
    17'd31887, 17'd35816, 17'd37937, 17'd42589,
    17'd47801, 17'd50607, 17'd56818, 17'd63775,
    17'd71633, 17'd75872, 17'd85178, 17'd95602
  };

endpackage

// File: rtl/prio_enc.sv
// Highest-set-bit encoder; valid is low and idx is 0 when no request bit is set.
module prio_enc #(
  parameter int W     = 16,
  parameter int IDX_W = 4
) (
  input  logic [W-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_generator.sv
// Keypad buzzer driver: highest held key selects the note, with release tail, click mode and mute.
//
// state   | meaning
// S_IDLE  | silent, cnt/beep held at 0, mode_click sampled here
// S_TONE  | sounding the winning held key, pitch changes adopted at wrap
// S_HOLD  | all keys released, last note continues for HOLD_CYCLES
// S_CLICK | one-shot note for CLICK_CYCLES, key activity ignored
module tone_generator
  import tone_pkg::*;
#(
  parameter int NUM_KEYS     = 16,
  parameter int CNT_W        = 17,
  parameter int HOLD_CYCLES  = CLK_HZ / 10,
  parameter int CLICK_CYCLES = CLK_HZ / 20,
  parameter int PERIOD_SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_status,
  input  logic                mode_click,
  input  logic                mute,
  output logic                beep,
  output logic                active,
  output logic [3:0]          cur_key
);

  localparam logic [31:0] HOLD_LOAD  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] CLICK_LOAD = 32'(CLICK_CYCLES - 1);

  state_t              state, state_nx;
  logic [NUM_KEYS-1:0] key_q, key_prev;
  logic [CNT_W-1:0]    cnt, cnt_nx, half;
  logic [31:0]         dur, dur_nx;
  logic [3:0]          cur_key_nx;
  logic                beep_raw, beep_nx, wrap;
  logic [3:0]          held_idx, press_idx;
  logic                held_valid, press_valid;

  prio_enc #(.W(NUM_KEYS), .IDX_W(4)) u_held (
    .req   (key_q),
    .idx   (held_idx),
    .valid (held_valid)
  );

  prio_enc #(.W(NUM_KEYS), .IDX_W(4)) u_press (
    .req   (key_q & ~key_prev),
    .idx   (press_idx),
    .valid (press_valid)
  );

  assign half = CNT_W'(NOTE_HALF[cur_key] >> PERIOD_SHIFT);
  assign wrap = (cnt == half - 1'b1);
  assign beep = beep_raw & ~mute;

  always_comb begin
    state_nx   = state;
    cur_key_nx = cur_key;
    dur_nx     = dur;
    case (state)
      S_IDLE: begin
        if (!mode_click && held_valid) begin
          state_nx   = S_TONE;
          cur_key_nx = held_idx;
        end else if (mode_click && press_valid) begin
          state_nx   = S_CLICK;
          cur_key_nx = press_idx;
          dur_nx     = CLICK_LOAD;
        end
      end
      S_TONE: begin
        if (!held_valid) begin
          if (HOLD_CYCLES == 0) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_HOLD;
            dur_nx   = HOLD_LOAD;
          end
        end else if (wrap) begin
          cur_key_nx = held_idx;
        end
      end
      S_HOLD: begin
        if (held_valid) state_nx = S_TONE;
        else if (dur == '0) state_nx = S_IDLE;
        else dur_nx = dur - 1'b1;
      end
      S_CLICK: begin
        if (dur == '0) state_nx = S_IDLE;
        else dur_nx = dur - 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase

    if (state_nx == S_IDLE) cur_key_nx = '0;

    // Leaving IDLE starts from cnt = 0; entering IDLE silences immediately.
    if (state == S_IDLE || state_nx == S_IDLE) begin
      cnt_nx  = '0;
      beep_nx = 1'b0;
    end else if (wrap) begin
      cnt_nx  = '0;
      beep_nx = ~beep_raw;
    end else begin
      cnt_nx  = cnt + 1'b1;
      beep_nx = beep_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      key_prev <= '0;
      cnt      <= '0;
      beep_raw <= 1'b0;
      dur      <= '0;
      cur_key  <= '0;
      active   <= 1'b0;
    end else begin
      key_q    <= key_status;
      key_prev <= key_q;
      cnt      <= cnt_nx;
      beep_raw <= beep_nx;
      dur      <= dur_nx;
      cur_key  <= cur_key_nx;
      active   <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: doc/tone_generator.md
# tone_generator

Parametrised successor to the keypad buzzer driver: converts a vector of key-held flags into a square-wave `beep` whose pitch comes from a shared note table. It adds several behaviours:
- a defined priority when several keys are held;
- glitch-free pitch changes;
- a release tail and a one-shot "click" mode;
- mute and status outputs.

It sits between the debounced keypad scanner and the buzzer pin.

## Interface
- `NUM_KEYS`, 16: number of key inputs, 1..16; key i uses note table entry i.
- `CNT_W`, 17: half-period counter width; must hold the largest table entry.
- `HOLD_CYCLES`, 5_000_000: release tail length in clk cycles, 100 ms at 50 MHz; 0 means no tail.
- `CLICK_CYCLES`, 2_500_000: one-shot tone length in click mode.
- `PERIOD_SHIFT`, 0: right-shift applied to table entries; simulation speed-up only.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_status` in NUM_KEYS: 1 = key held; already debounced.
- `mode_click` in 1: 0 = continuous mode, 1 = click mode.
- `mute` in 1: forces `beep` to 0.
- `beep` out 1: square wave to the buzzer.
- `active` out 1: high when the FSM is not in IDLE.
- `cur_key` out 4: index of the key currently sounding; 0 when idle.

## Operation
- **Input stage**
  - `key_status` is registered once into `key_q`.
  - The previous value is also kept, to detect press edges.
- **Priority**
  - The highest set index in `key_q` wins.
  - Its half-period is `H = NOTE_HALF[idx] >> PERIOD_SHIFT`; H is never 0 after the shift.
- **Tone counter**
  - `cnt` counts 0..H-1.
  - At H-1 it wraps to 0 and `beep_raw` toggles.
  - A pitch change updates the latched `cur_key` only at a wrap, so no runt half-cycle is produced.
- **FSM states:** IDLE, TONE, HOLD, CLICK.
- **IDLE**
  - `cnt` = 0, `beep_raw` = 0.
  - `mode_click` is sampled only here.
  - Continuous mode with any `key_q` bit set: go to TONE and latch the winner.
  - Click mode with any press edge (`key_q & ~key_prev` nonzero): go to CLICK, latch the highest newly pressed key, load the duration counter with CLICK_CYCLES-1.
- **TONE**
  - Sounds the tone.
  - If the winner changes, the new key is adopted at the next wrap.
  - When all keys are released: go to HOLD with the duration counter set to HOLD_CYCLES-1. If HOLD_CYCLES = 0, go straight to IDLE.
- **HOLD**
  - Keeps sounding the last key.
  - Any `key_q` bit set returns to TONE.
  - When the counter reaches 0, go to IDLE.
- **CLICK**
  - Sounds the latched key for exactly CLICK_CYCLES cycles, then goes to IDLE.
  - Presses and releases during CLICK are ignored.
- **Entering IDLE:** `beep_raw` clears on that same cycle, even mid half-period.
- **Mute:** `beep = beep_raw & ~mute`. The FSM and counters keep running while muted.
- **Reset** (any time, including mid-tone):
  - state = IDLE, `cnt` = 0;
  - `key_q` = 0, `key_prev` = 0;
  - `beep` = 0, `active` = 0, `cur_key` = 0.

## Timing
- A press sampled at edge N sets `key_q` at N. The FSM enters TONE at N+1, with `cnt` = 0 from that cycle.
- The first `beep` rise comes H cycles after entering TONE, giving a square wave of period 2H.
- Release to HOLD takes 2 cycles. The tail lasts HOLD_CYCLES cycles, then `beep` is 0 on the cycle IDLE is entered.
- The click tone lasts exactly CLICK_CYCLES cycles from entry to CLICK.
- `active` and `cur_key` are registered and change on the same edge as the state.
- `mute` takes effect on `beep` combinationally.

## Structure
- The package `tone_pkg` holds:
  - the `NOTE_HALF[0:15]` table (half-period cycle counts at 50 MHz): 21294, 23900, 25303, 28409, 31887, 35816, 37937, 42589, 47801, 50607, 56818, 63775, 71633, 75872, 85178, 95602;
  - the FSM state enum;
  - the constant `CLK_HZ = 50_000_000`.
- One natural sub-module: `prio_enc`, a parametrised highest-set-bit encoder producing an index and a valid flag. It is used for both held keys and press edges.

## Test plan
All runs use PERIOD_SHIFT = 8, HOLD_CYCLES = 500, CLICK_CYCLES = 300.
- **Single key:** hold key 0 → `beep` period 166 cycles (H = 83), first rise 84 cycles after `key_q` sets; `cur_key` = 0.
- **Multi-key priority:** hold keys 3 and 9 → H = 197 (key 9). Release key 9 mid half-period → the switch to H = 110 happens only at the next wrap, with no shorter pulse.
- **Release tail:** release all keys → tone continues 500 cycles, then `beep` = 0 and `active` = 0. Re-press at tail cycle 200 → back in TONE, tone uninterrupted.
- **Click mode:** press key 15 for 10 cycles → tone H = 373 for exactly 300 cycles. A second press during CLICK is ignored.
- **Mute:** assert `mute` mid-tone → `beep` = 0 immediately. Deassert → phase continues unchanged.
- **Reset mid-tone:** pulse `rst_n` low asynchronously → all outputs 0 at once. After release with the key still held → TONE re-entered, first rise H+1 cycles later.
